// File: rtl/riscv_pipe_skid_register.sv
// -----------------------------------------------------------------------------
// riscv_pipe_skid_register
//
// Generic valid/ready pipeline-stage register for the pipelined RV32I core.
// It has a main register that drives o_data/o_valid and a one-entry skid
// register. Together they hold two entries, so the stage sustains one transfer
// per cycle. o_ready comes straight from a flop, which cuts every combinational
// path from i_valid/i_ready to o_ready. The stage can sit between any two
// pipeline stages (F/D, D/E, E/M, M/W).
//
// Parameters
//   DWIDTH     payload width in bits
//   RESET_VAL  o_data (and skid) contents after reset
//   FLUSH_VAL  o_data (and skid) contents after a flush, e.g. a NOP for F/D
//
// Ports
//   i_clk        in   1       clock, rising edge
//   i_rstn       in   1       asynchronous active-low reset
//   i_valid      in   1       upstream payload valid
//   o_ready      out  1       stage can accept (registered)
//   i_data       in   DWIDTH  upstream payload
//   o_valid      out  1       downstream payload valid (registered)
//   i_ready      in   1       downstream accepts
//   o_data       out  DWIDTH  downstream payload (registered)
//   i_flush      in   1       synchronous kill of every held entry
//   o_stall_cnt  out  32      stall-cycle counter      (RISCV_PIPE_STAT_EN only)
//   o_flush_cnt  out  32      effective-flush counter  (RISCV_PIPE_STAT_EN only)
//
// Build option
//   RISCV_PIPE_STAT_EN : when defined, adds the two saturating statistics
//                        counters and their ports. The datapath is the same
//                        whether or not it is defined.
// -----------------------------------------------------------------------------
module riscv_pipe_skid_register #(
  parameter int                DWIDTH    = 96,
  parameter logic [DWIDTH-1:0] RESET_VAL = '0,
  parameter logic [DWIDTH-1:0] FLUSH_VAL = '0
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DWIDTH-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DWIDTH-1:0] o_data,
  input  logic              i_flush
`ifdef RISCV_PIPE_STAT_EN
  ,
  output logic [31:0]       o_stall_cnt,
  output logic [31:0]       o_flush_cnt
`endif
);

  // EMPTY: nothing held. FULL: main holds an entry. SKID: main and skid both
  // hold an entry, and skid holds the younger one.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [DWIDTH-1:0]   main_reg,  main_next;
  logic [DWIDTH-1:0]   skid_reg,  skid_next;
  logic                valid_reg, valid_next;
  logic                ready_reg, ready_next;

  logic                in_fire;
  logic                out_fire;

  // Both handshakes use only registered stage outputs, so nothing combinational
  // feeds back into o_ready or o_valid.
  assign in_fire  = i_valid & ready_reg;
  assign out_fire = valid_reg & i_ready;

  assign o_valid  = valid_reg;
  assign o_ready  = ready_reg;
  assign o_data   = main_reg;

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;

    if (i_flush) begin
      // A flush overrides everything. An input accepted in this cycle is
      // dropped. An output taken in this cycle has already been consumed
      // downstream, so discarding the main entry loses nothing.
      state_next = ST_EMPTY;
      main_next  = FLUSH_VAL;
      skid_next  = FLUSH_VAL;
    end else begin
      unique case (state_reg)
        ST_EMPTY: begin
          if (in_fire) begin
            main_next  = i_data;
            state_next = ST_FULL;
          end
        end

        ST_FULL: begin
          unique case ({in_fire, out_fire})
            2'b11: begin
              // Pass-through: the new entry replaces the one leaving.
              main_next = i_data;
            end
            2'b10: begin
              // Downstream is stalled. Park the new entry in skid and leave
              // main (and so o_data) untouched.
              skid_next  = i_data;
              state_next = ST_SKID;
            end
            2'b01: begin
              // Main drains. o_data keeps its stale value; o_valid drops.
              state_next = ST_EMPTY;
            end
            default: begin
              state_next = ST_FULL;
            end
          endcase
        end

        ST_SKID: begin
          // o_ready is low here, so no input can arrive.
          if (out_fire) begin
            main_next  = skid_reg;
            state_next = ST_FULL;
          end
        end

        default: begin
          state_next = ST_EMPTY;
        end
      endcase
    end
  end

  // Compute the handshake flags from the next state so that both are plain
  // flop outputs.
  always_comb begin
    valid_next = (state_next != ST_EMPTY);
    ready_next = (state_next != ST_SKID);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg <= ST_EMPTY;
      main_reg  <= RESET_VAL;
      skid_reg  <= RESET_VAL;
      valid_reg <= 1'b0;
      ready_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
      valid_reg <= valid_next;
      ready_reg <= ready_next;
    end
  end

`ifdef RISCV_PIPE_STAT_EN
  // ---------------------------------------------------------------------------
  // Statistics: saturating counters. A flush does not clear them; only reset
  // does.
  // ---------------------------------------------------------------------------
  logic [31:0] stall_cnt_reg, stall_cnt_next;
  logic [31:0] flush_cnt_reg, flush_cnt_next;
  logic        stall_evt;
  logic        flush_evt;

  assign stall_evt = valid_reg & ~i_ready;
  // A flush counts only when it actually kills something.
  assign flush_evt = i_flush & (state_reg != ST_EMPTY);

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    flush_cnt_next = flush_cnt_reg;
    if (stall_evt && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_next = stall_cnt_reg + 32'd1;
    end
    if (flush_evt && (flush_cnt_reg != 32'hFFFF_FFFF)) begin
      flush_cnt_next = flush_cnt_reg + 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stall_cnt_reg <= 32'd0;
      flush_cnt_reg <= 32'd0;
    end else begin
      stall_cnt_reg <= stall_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  assign o_stall_cnt = stall_cnt_reg;
  assign o_flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_riscv_pipe_skid_register.sv
// -----------------------------------------------------------------------------
// tb_riscv_pipe_skid_register
//
// Self-checking bench for riscv_pipe_skid_register. The reference model treats
// the stage as a FIFO of at most two entries (a queue):
//   - the stage is ready when fewer than two entries are held;
//   - it is valid when at least one entry is held;
//   - o_data is the head entry, or the last value left behind once empty.
// Directed sequences are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_riscv_pipe_skid_register;

  localparam int          DW        = 96;
  localparam logic [95:0] RST_VAL   = 96'h0000_00A5_0000_0000_DEAD_BEEF;
  localparam logic [95:0] FLUSH_VAL = 96'h0000_0013_0000_0000_0000_0013;

  logic          clk;
  logic          rstn;
  logic          in_valid;
  logic          out_ready_dut;
  logic [DW-1:0] in_data;
  logic          out_valid_dut;
  logic          ds_ready;
  logic [DW-1:0] out_data_dut;
  logic          flush;
`ifdef RISCV_PIPE_STAT_EN
  logic [31:0]   stall_cnt_dut;
  logic [31:0]   flush_cnt_dut;
`endif

  riscv_pipe_skid_register #(
    .DWIDTH    (DW),
    .RESET_VAL (RST_VAL),
    .FLUSH_VAL (FLUSH_VAL)
  ) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_valid     (in_valid),
    .o_ready     (out_ready_dut),
    .i_data      (in_data),
    .o_valid     (out_valid_dut),
    .i_ready     (ds_ready),
    .o_data      (out_data_dut),
    .i_flush     (flush)
`ifdef RISCV_PIPE_STAT_EN
    ,
    .o_stall_cnt (stall_cnt_dut),
    .o_flush_cnt (flush_cnt_dut)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counters and reference-model state.
  int          check_cnt = 0;
  int          fail_cnt  = 0;
  int          xfer_cnt  = 0;
  logic [95:0] mq[$];
  logic [95:0] m_held;
  longint      m_stall;
  longint      m_flush;

  task automatic check_val(input string tag, input logic [95:0] got,
                           input logic [95:0] exp);
    check_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [95:0] sat32(input longint v);
    return (v > 64'hFFFF_FFFF) ? 96'hFFFF_FFFF : 96'(v);
  endfunction

  // Called at a negedge. It compares the DUT against the model, applies the
  // inputs, advances the model across the next posedge, and returns at the
  // following negedge.
  task automatic step(input logic v, input logic [95:0] d,
                      input logic r, input logic f);
    bit in_f;
    bit out_f;
    logic [95:0] popped;
    check_val("o_valid", 96'(out_valid_dut), 96'(mq.size() > 0));
    check_val("o_ready", 96'(out_ready_dut), 96'(mq.size() < 2));
    check_val("o_data",  out_data_dut, (mq.size() > 0) ? mq[0] : m_held);
`ifdef RISCV_PIPE_STAT_EN
    check_val("stall_cnt", 96'(stall_cnt_dut), sat32(m_stall));
    check_val("flush_cnt", 96'(flush_cnt_dut), sat32(m_flush));
`endif
    in_valid = v;
    in_data  = d;
    ds_ready = r;
    flush    = f;
    in_f  = v && (mq.size() < 2);
    out_f = (mq.size() > 0) && r;
    if ((mq.size() > 0) && !r) m_stall++;
    if (f && (mq.size() > 0))  m_flush++;
    if (out_f) begin
      popped = mq.pop_front();
      m_held = popped;
      xfer_cnt++;
      $display("xfer %0d data=%h", xfer_cnt, popped);
    end
    if (f) begin
      mq.delete();
      m_held = FLUSH_VAL;
    end else if (in_f) begin
      mq.push_back(d);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asserts the asynchronous reset between clock edges and checks that it
  // takes effect immediately. Returns at a negedge with reset released.
  task automatic async_reset();
    #2;
    rstn = 1'b0;
    #1;
    check_val("rst_o_valid", 96'(out_valid_dut), 96'd0);
    check_val("rst_o_ready", 96'(out_ready_dut), 96'd1);
    check_val("rst_o_data",  out_data_dut, RST_VAL);
    mq.delete();
    m_held  = RST_VAL;
    m_stall = 0;
    m_flush = 0;
    in_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  logic [95:0] rnd;

  initial begin
    rstn     = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    ds_ready = 1'b0;
    flush    = 1'b0;
    m_held   = RST_VAL;
    m_stall  = 0;
    m_flush  = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Stream A..D with the consumer always ready: one-cycle latency, and
    // o_ready never drops.
    step(1, 96'hA, 1, 0);
    step(1, 96'hB, 1, 0);
    step(1, 96'hC, 1, 0);
    step(1, 96'hD, 1, 0);
    step(0, 96'h0, 1, 0);
    step(0, 96'h0, 1, 0);

    // Consumer stalled: A fills main, B goes to skid, A is held. Then release.
    step(1, 96'hA, 0, 0);
    step(1, 96'hB, 0, 0);
    step(1, 96'hF, 0, 0);   // refused: the stage is full
    step(0, 96'h0, 1, 0);
    step(0, 96'h0, 1, 0);
    step(0, 96'h0, 1, 0);

    // Flush in SKID while offering E. E must never appear downstream.
    step(1, 96'h1A, 0, 0);
    step(1, 96'h1B, 0, 0);
    step(1, 96'hE,  0, 1);
    check_val("flush_o_data", out_data_dut, FLUSH_VAL);
    step(0, 96'h0, 1, 0);
    step(0, 96'h0, 1, 0);

    // From FULL, 0x1..0x10 back to back with no bubbles.
    step(1, 96'h99, 0, 0);
    for (int i = 1; i <= 16; i++) step(1, 96'(i), 1, 0);
    step(0, 96'h0, 1, 0);
    step(0, 96'h0, 1, 0);

    // Reset asserted in the middle of a stream.
    step(1, 96'h55, 1, 0);
    step(1, 96'h66, 0, 0);
    async_reset();

    // Counter scenario: 5 stall cycles, a flush in FULL, then a flush in EMPTY.
    step(1, 96'h77, 0, 0);
    repeat (5) step(0, 96'h0, 0, 0);
    step(0, 96'h0, 1, 1);
    step(0, 96'h0, 1, 1);
    step(0, 96'h0, 1, 0);
`ifdef RISCV_PIPE_STAT_EN
    check_val("t6_stall_cnt", 96'(stall_cnt_dut), 96'd5);
    check_val("t6_flush_cnt", 96'(flush_cnt_dut), 96'd1);
`endif

    // Randomized phase, with one reset part way through.
    for (int n = 0; n < 400; n++) begin
      rnd = {$urandom, $urandom, $urandom};
      step(1'($urandom_range(0, 3) != 0), rnd,
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 19) == 0));
      if (n == 200) async_reset();
    end
    step(0, 96'h0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
    $finish;
  end

endmodule
